sgd_wr_arbiter: RTL

SGD_WR_ARBITER -- requirements
Module: sgd_wr_arbiter

---
 rtl/sgd_wr_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sgd_wr_arbiter.sv
// Two-requester write arbiter feeding a single registered memory write port.
// Grants are burst-locked for BURST_LEN beats and ties alternate between requesters.
module sgd_wr_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_BITS  = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [57:0]  req0_wr_addr,
    input  logic [7:0]   req0_wr_tag,
    input  logic         req0_wr_valid,
    input  logic [511:0] req0_tx_data,
    output logic         req0_wr_ready,
    input  logic [57:0]  req1_wr_addr,
    input  logic [7:0]   req1_wr_tag,
    input  logic         req1_wr_valid,
    input  logic [511:0] req1_tx_data,
    output logic         req1_wr_ready,
    output logic [57:0]  um_tx_wr_addr,
    output logic [7:0]   um_tx_wr_tag,
    output logic [511:0] um_tx_data,
    output logic         um_tx_wr_valid,
    input  logic         um_tx_wr_ready,
    output logic [31:0]  state_counters_wr_arbiter
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [CNT_BITS-1:0] beat_cnt_q, beat_cnt_d;
    logic [13:0]         beats0_q, beats1_q;
    logic                um_valid_q;
    logic [57:0]         um_addr_q;
    logic [7:0]          um_tag_q;
    logic [511:0]        um_data_q;

    logic out_free;
    logic acc0, acc1, acc;
    logic burst_end;

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free  = ~um_valid_q | um_tx_wr_ready;
    assign acc0      = req0_wr_valid & req0_wr_ready;
    assign acc1      = req1_wr_valid & req1_wr_ready;
    assign acc       = acc0 | acc1;
    assign burst_end = acc & (beat_cnt_q == CNT_BITS'(BURST_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (req0_wr_valid && req1_wr_valid) begin
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                end else if (req0_wr_valid) begin
                    state_d = GRANT0;
                end else if (req1_wr_valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (acc) beat_cnt_d = beat_cnt_q + CNT_BITS'(1);
                if (burst_end) begin
                    beat_cnt_d   = '0;
                    last_grant_d = 1'b0;
                    state_d      = req1_wr_valid ? GRANT1 : (req0_wr_valid ? GRANT0 : IDLE);
                end
            end
            GRANT1: begin
                if (acc) beat_cnt_d = beat_cnt_q + CNT_BITS'(1);
                if (burst_end) begin
                    beat_cnt_d   = '0;
                    last_grant_d = 1'b1;
                    state_d      = req0_wr_valid ? GRANT0 : (req1_wr_valid ? GRANT1 : IDLE);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_wr_ready = (state_q == GRANT0) & out_free;
        req1_wr_ready = (state_q == GRANT1) & out_free;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            um_valid_q <= 1'b0;
            beats0_q   <= '0;
            beats1_q   <= '0;
        end else begin
            if (out_free) um_valid_q <= acc;
            if (acc0) beats0_q <= beats0_q + 14'd1;
            if (acc1) beats1_q <= beats1_q + 14'd1;
        end
    end

    // Payload needs no reset: it is only observed while um_tx_wr_valid is high.
    always_ff @(posedge clk) begin
        if (out_free && acc) begin
            um_addr_q <= acc1 ? req1_wr_addr : req0_wr_addr;
            um_tag_q  <= acc1 ? req1_wr_tag  : req0_wr_tag;
            um_data_q <= acc1 ? req1_tx_data : req0_tx_data;
        end
    end

    assign um_tx_wr_valid = um_valid_q;
    assign um_tx_wr_addr  = um_addr_q;
    assign um_tx_wr_tag   = um_tag_q;
    assign um_tx_data     = um_data_q;
    assign state_counters_wr_arbiter = {beats1_q, beats0_q, 2'b00, state_q};

endmodule
